// File: rtl/sub_bytes_iter_pkg.sv
// ============================================================================
// aes_pkg : shared AES widths, SubBytes FSM states and the forward S-box table
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX_TABLE[8*(255 - int'(b)) +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_bytes_iter_sbox.sv
// ============================================================================
// sbox : 8-bit combinational forward AES S-box
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] out
);

  assign out = sbox_f(in);

endmodule

`default_nettype wire

// File: rtl/sub_bytes_iter.sv
// ============================================================================
// sub_bytes_iter : iterative forward SubBytes, BYTES_PER_CYCLE bytes per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int N_STEPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int IDX_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int GROUP_W = 8 * BYTES_PER_CYCLE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [IDX_W-1:0]       r_idx;
  logic [AES_BLOCK_W-1:0] r_work;
  logic                   r_drain;
  logic [GROUP_W-1:0]     w_group_in;
  logic [GROUP_W-1:0]     w_group_out;

  always_comb begin
    w_group_in = '0;
    for (int g = 0; g < N_STEPS; g++) begin
      if (r_idx == IDX_W'(g)) begin
        w_group_in = r_work[g*GROUP_W +: GROUP_W];
      end
    end
  end

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    sbox u_sbox (
      .in  (w_group_in[8*b +: 8]),
      .out (w_group_out[8*b +: 8])
    );
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (r_drain) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // r_drain marks the settle cycle after the last group is written back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_work  <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          r_drain <= 1'b0;
          if (in_valid) begin
            r_work <= in_data;
            r_idx  <= '0;
          end
        end
        BUSY: begin
          if (!r_drain) begin
            for (int g = 0; g < N_STEPS; g++) begin
              if (r_idx == IDX_W'(g)) begin
                r_work[g*GROUP_W +: GROUP_W] <= w_group_out;
              end
            end
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_drain <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_drain <= 1'b0;
      endcase
    end
  end

  assign out_data = r_work;

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
// ============================================================================
// tb_sub_bytes_iter : checks three widths of sub_bytes_iter against a GF(2^8) model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] in_data   [3];
  logic [127:0] out_data  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));

  sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));

  sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  // Expected accept-to-out_valid latency: 16/BPC + 1 for BPC = 4, 1, 16.
  function automatic int lat_of(input int d);
    case (d)
      0:       return 5;
      1:       return 17;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: inverse in GF(2^8) then the affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox(st[8*k +: 8]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready[d]), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid[d]), 128'd0);
    chk({tag, "_busy"}, 128'(busy[d]), 128'd0);
  endtask

  task automatic accept(input int d, input logic [127:0] data);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic run(input int d, input logic [127:0] data, input logic [127:0] exp,
                     input bit bp, input string tag);
    int cyc = 0;
    accept(d, data);
    while (!out_valid[d] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(lat_of(d)));
    chk({tag, "_data"}, out_data[d], exp);
    chk({tag, "_busy_done"}, 128'(busy[d]), 128'd1);
    chk({tag, "_in_ready_done"}, 128'(in_ready[d]), 128'd0);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        in_valid[d] = i[0];
        @(posedge clk); #1;
        chk({tag, "_bp_valid"}, 128'(out_valid[d]), 128'd1);
        chk({tag, "_bp_data"}, out_data[d], exp);
        chk({tag, "_bp_in_ready"}, 128'(in_ready[d]), 128'd0);
      end
      in_valid[d] = 1'b0;
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk_idle(d, {tag, "_release"});
  endtask

  initial begin
    logic [127:0] v;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_data[d]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_idle(d, "reset");
      chk("reset_out_data", out_data[d], 128'd0);
    end
    rst = 1'b0;

    run(0, 128'd0, {16{8'h63}}, 1'b0, "zero");
    run(0, {{12{8'hff}}, 32'hbee33d19}, {{12{8'h16}}, 32'hae1127d4}, 1'b0, "fips");

    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    run(0, v, ref_sub(v), 1'b1, "backpressure");

    // Reset lands on the edge where the second group would be written.
    accept(0, {$urandom(), $urandom(), $urandom(), $urandom()});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(0, "midrst");
    chk("midrst_out_data", out_data[0], 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_valid", 128'(out_valid[0]), 128'd0);
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    run(0, v, ref_sub(v), 1'b0, "after_rst");

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 3; n++) begin
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        run(d, v, ref_sub(v), 1'b0, $sformatf("rand_d%0d_n%0d", d, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
